// File: rtl/bcd_disp_mux.sv
// bcd_disp_mux
//   Time-multiplexed seven-segment driver for packed BCD digits. It scans
//   N_DIG digits and shows each one for 2**REF_W clocks. The input is
//   snapshotted once per scan frame, so a value that changes mid-scan never
//   tears on the display. Leading zeros can be blanked. Each digit has its own
//   decimal point. A nibble that is not valid BCD is shown as a dash.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : synchronous reset, active-low
//   bcd        : packed BCD, digit k = bcd[4k+3:4k], digit 0 is the rightmost
//   dp         : decimal point per digit, active-high
//   blank_en   : 1 = suppress leading zeros
//   an         : anode enables, active-low (one-hot-low, or all ones when blanked)
//   sseg       : {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick : one-cycle pulse on the first output cycle of a new frame
module bcd_disp_mux #(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned REF_W = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4*N_DIG-1:0] bcd,
    input  logic [N_DIG-1:0]   dp,
    input  logic               blank_en,
    output logic [N_DIG-1:0]   an,
    output logic [7:0]         sseg,
    output logic               frame_tick
);

    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [REF_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*N_DIG-1:0] frm_bcd_q, frm_bcd_d;
    logic [N_DIG-1:0]   frm_dp_q, frm_dp_d;
    logic               frm_blank_q, frm_blank_d;
    logic               new_frame_q, new_frame_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic               tick_q, tick_d;

    logic               cnt_wrap;
    logic               last_dig;
    logic               snap;

    // Segment pattern {g..a}, active-low. Non-BCD nibbles show a dash.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Prescaler, digit index and frame snapshot
    always_comb begin
        cnt_wrap    = (cnt_q == '1);
        last_dig    = (idx_q == IDX_W'(N_DIG - 1));
        snap        = cnt_wrap && last_dig;

        cnt_d       = cnt_q + REF_W'(1);
        idx_d       = idx_q;
        if (cnt_wrap) begin
            idx_d = last_dig ? '0 : idx_q + IDX_W'(1);
        end

        frm_bcd_d   = frm_bcd_q;
        frm_dp_d    = frm_dp_q;
        frm_blank_d = frm_blank_q;
        if (snap) begin
            frm_bcd_d   = bcd;
            frm_dp_d    = dp;
            frm_blank_d = blank_en;
        end

        // High in the one cycle where idx==0 first refers to the new frame.
        new_frame_d = snap;
    end

    // Output decode from the current index and the frozen frame
    logic [N_DIG-1:0] keep;
    logic             any_nz;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             cur_keep;

    always_comb begin
        // A digit is lit when it or any higher digit is nonzero. Digit 0 is
        // always lit, and every digit is lit when blanking is off.
        keep   = '0;
        any_nz = 1'b0;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            int unsigned k;
            k       = N_DIG - 1 - i;
            any_nz  = any_nz | (frm_bcd_q[4*k +: 4] != 4'd0);
            keep[k] = any_nz || (k == 0) || !frm_blank_q;
        end

        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_keep = 1'b0;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib  = frm_bcd_q[4*k +: 4];
                cur_dp   = frm_dp_q[k];
                cur_keep = keep[k];
            end
        end

        if (cur_keep) begin
            an_d   = ~(N_DIG'(1) << idx_q);
            sseg_d = {~cur_dp, seg_code(cur_nib)};
        end else begin
            an_d   = '1;
            sseg_d = '1;
        end
        tick_d = new_frame_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            frm_bcd_q   <= '0;
            frm_dp_q    <= '0;
            frm_blank_q <= 1'b0;
            new_frame_q <= 1'b0;
            an_q        <= '1;
            sseg_q      <= '1;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frm_bcd_q   <= frm_bcd_d;
            frm_dp_q    <= frm_dp_d;
            frm_blank_q <= frm_blank_d;
            new_frame_q <= new_frame_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule
